mmio_responder: RTL and testbench

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_pkg.sv | 44 ++++
 rtl/mmio_ram.sv | 48 ++++
 rtl/mmio_responder.sv | 153 +++++++++++++++
 tb/tb_mmio_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO responder.
//   - Address constants for the LED, CYCLES and STATUS registers.
//   - region_e: the target of a request after address decode.
//   - state_e: responder handshake FSM states.
//   - decode_region(): combinational address decoder. RAM is checked first,
//     so a RAM region large enough to reach 0x1000 would shadow the registers.
package mmio_pkg;

  localparam logic [31:0] LED_ADDR    = 32'h0000_1000;
  localparam logic [31:0] CYCLES_ADDR = 32'h0000_1004;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_1008;

  typedef enum logic [2:0] {
    REG_RAM    = 3'd0,
    REG_LED    = 3'd1,
    REG_CYCLES = 3'd2,
    REG_STATUS = 3'd3,
    REG_NONE   = 3'd4
  } region_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Map a byte address to its region; ram_bytes is the RAM size in bytes.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes);
    region_e region;
    if (addr < ram_bytes) begin
      region = REG_RAM;
    end else if (addr == LED_ADDR) begin
      region = REG_LED;
    end else if (addr == CYCLES_ADDR) begin
      region = REG_CYCLES;
    end else if (addr == STATUS_ADDR) begin
      region = REG_STATUS;
    end else begin
      region = REG_NONE;
    end
    return region;
  endfunction

endpackage

// File: rtl/mmio_ram.sv
// mmio_ram: byte-enabled single-port synchronous RAM, write-first read.
// Ports:
//   clk   - clock
//   en    - access enable; no read or write happens when low
//   we    - 1 = write the strobed bytes, 0 = read only
//   addr  - word index
//   wdata - write data
//   wstrb - byte enables, bit n covers wdata[8n+7:8n]
//   rdata - registered read data; on a write it returns the merged new word
//           and it holds its value while en is low
// Contents are deliberately not reset.
module mmio_ram #(
  parameter int RAM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [$clog2(RAM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  input  logic [3:0]                   wstrb,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [RAM_WORDS];
  logic [31:0] cur_word;
  logic [31:0] merged;

  assign cur_word = mem[addr];

  // Merge strobed write bytes over the current word (also the write-first read value).
  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = (we && wstrb[b]) ? wdata[8*b +: 8] : cur_word[8*b +: 8];
    end
  end

  // Storage write and registered read port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= merged;
      end
      rdata <= merged;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: single-outstanding MMIO slave for a core data port.
// Map: RAM at 0 (RAM_WORDS words), LED 0x1000, CYCLES 0x1004, STATUS 0x1008.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb - request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                     - response channel
//   led_out                                                   - LED register
// Optional feature: define MMIO_CYCLE_COUNTER_EN to build the free-running
// CYCLES counter; without it CYCLES reads 0 and ignores stores.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  led_out
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  state_e      state;
  region_e     region;
  logic        accept;
  logic        err;
  logic        last_err;
  logic        sel_ram;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic [31:0] reg_rdata;
  logic [31:0] rd_mux;
  logic [31:0] cycles_val;

  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  assign region = decode_region(req_addr, RAM_BYTES);
  // Misaligned, unmapped, or a store to the read-only STATUS register.
  assign err = (req_addr[1:0] != 2'b00) || (region == REG_NONE) ||
               (req_write && (region == REG_STATUS));

  assign ram_en = accept && !err && (region == REG_RAM);

  mmio_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (req_write),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (ram_rdata)
  );

  // Register-side load data; RAM loads come from the RAM read port instead.
  always_comb begin
    rd_mux = 32'd0;
    if (err || req_write) begin
      rd_mux = 32'd0;
    end else begin
      case (region)
        REG_LED:    rd_mux = {26'd0, led_out};
        REG_CYCLES: rd_mux = cycles_val;
        REG_STATUS: rd_mux = {31'd0, last_err};
        default:    rd_mux = 32'd0;
      endcase
    end
  end

  // Both sources are registered at accept, so the response stays stable while stalled.
  assign rsp_rdata = sel_ram ? ram_rdata : reg_rdata;

  // Handshake FSM plus response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      reg_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      sel_ram   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= RESP;
          else        state <= IDLE;
        end
        RESP: begin
          if (accept)         state <= RESP;
          else if (rsp_ready) state <= IDLE;
          else                state <= RESP;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        reg_rdata <= rd_mux;
        rsp_err   <= err;
        sel_ram   <= (region == REG_RAM) && !err && !req_write;
      end
    end
  end

  // LED register: only byte lane 0 carries the six LED bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= 6'd0;
    end else if (accept && !err && req_write && (region == REG_LED) && req_wstrb[0]) begin
      led_out <= req_wdata[5:0];
    end
  end

  // Sticky error flag: a STATUS load clears it, but a new error on the same edge wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_err <= 1'b0;
    end else if (accept && err) begin
      last_err <= 1'b1;
    end else if (accept && !req_write && (region == REG_STATUS)) begin
      last_err <= 1'b0;
    end
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycles;
  logic        cyc_clear;

  assign cyc_clear  = accept && !err && req_write && (region == REG_CYCLES);
  assign cycles_val = cycles;

  // Free-running cycle counter; a store clears it and beats the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= 32'd0;
    end else if (cyc_clear) begin
      cycles <= 32'd0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end
`else
  assign cycles_val = 32'd0;
`endif

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed self-checking bench for mmio_responder.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  led_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] LED_A    = 32'h0000_1000;
  localparam logic [31:0] CYCLES_A = 32'h0000_1004;
  localparam logic [31:0] STATUS_A = 32'h0000_1008;

  mmio_responder #(.RAM_WORDS(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"},   {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  logic [31:0] exp_cyc;

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_wstrb = 4'd0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_led",   {26'd0, led_out}, 32'd0);
    reset = 1'b1;
    #1 check("rel_ready", {31'd0, req_ready}, 32'd1);

    // RAM full store, load, partial store
    xfer("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    xfer("ld_full", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    xfer("st_byte", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'd0, 1'b0);
    xfer("ld_byte", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEAA, 1'b0);
    xfer("st_nostrb", 1'b1, 32'h10, 32'h1234_5678, 4'b0000, 32'd0, 1'b0);
    xfer("ld_nostrb", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEAA, 1'b0);

    // RAM boundary: last word mapped, next word unmapped
    xfer("st_last", 1'b1, 32'h3FC, 32'hA5A5_0F0F, 4'hF, 32'd0, 1'b0);
    xfer("ld_last", 1'b0, 32'h3FC, 32'd0, 4'h0, 32'hA5A5_0F0F, 1'b0);
    xfer("ld_past", 1'b0, 32'h400, 32'd0, 4'h0, 32'd0, 1'b1);
    xfer("st_misal", 1'b1, 32'h3FD, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
    xfer("ld_last2", 1'b0, 32'h3FC, 32'd0, 4'h0, 32'hA5A5_0F0F, 1'b0);

    // LED: lane 0 strobe required
    xfer("led_st", 1'b1, LED_A, 32'hFFFF_FF2A, 4'b0001, 32'd0, 1'b0);
    check("led_out_2a", {26'd0, led_out}, 32'h2A);
    xfer("led_nolane0", 1'b1, LED_A, 32'h0000_003F, 4'b1110, 32'd0, 1'b0);
    check("led_keep", {26'd0, led_out}, 32'h2A);

    // Stalled LED load: response held, new request ignored, single handoff
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = LED_A;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1;
    req_wdata = 32'h0000_0015;
    req_wstrb = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'h2A);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("handoff_valid", {31'd0, rsp_valid}, 32'd0);
    check("stall_led", {26'd0, led_out}, 32'h2A);

    // STATUS store is an error; STATUS load reports and clears it
    xfer("st_status", 1'b1, STATUS_A, 32'd0, 4'hF, 32'd0, 1'b1);
    xfer("ld_status1", 1'b0, STATUS_A, 32'd0, 4'h0, 32'd1, 1'b0);

    // Back-to-back: misaligned unmapped load, then STATUS load
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h2002;
    @(posedge clk);
    @(negedge clk);
    check("b2b_valid0", {31'd0, rsp_valid}, 32'd1);
    check("b2b_err0",   {31'd0, rsp_err}, 32'd1);
    check("b2b_rdata0", rsp_rdata, 32'd0);
    check("b2b_ready",  {31'd0, req_ready}, 32'd1);
    req_addr = STATUS_A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_valid1", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rdata1", rsp_rdata, 32'd1);
    check("b2b_err1",   {31'd0, rsp_err}, 32'd0);
    xfer("ld_status2", 1'b0, STATUS_A, 32'd0, 4'h0, 32'd0, 1'b0);

    // CYCLES: clear, idle, load; the load is accepted 11 edges after the clear
`ifdef MMIO_CYCLE_COUNTER_EN
    exp_cyc = 32'd10;
`else
    exp_cyc = 32'd0;
`endif
    xfer("cyc_clr", 1'b1, CYCLES_A, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    xfer("cyc_ld", 1'b0, CYCLES_A, 32'd0, 4'h0, exp_cyc, 1'b0);

    // Reset mid-response
    xfer("led_3f", 1'b1, LED_A, 32'h0000_003F, 4'hF, 32'd0, 1'b0);
    xfer("unmapped", 1'b0, 32'h3000, 32'd0, 4'h0, 32'd0, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = LED_A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    check("pre_rst_rdata", rsp_rdata, 32'h3F);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_led",   {26'd0, led_out}, 32'd0);
    check("mid_rst_lasterr", {31'd0, dut.last_err}, 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    rsp_ready = 1'b1;
    #1 check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    xfer("post_status", 1'b0, STATUS_A, 32'd0, 4'h0, 32'd0, 1'b0);
    xfer("post_ram", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEAA, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
